// File: rtl/isa_pio_port.sv
// ISA-bus slave: NUM_PORTS 8-bit parallel ports plus a direction/control register at the top of the window.
// Latency: SD_OE 3 clk after IOR falls; write visible on PORT_OUT/PORT_DIR 4 clk after IOW rises.
// Backpressure: none; the ISA strobe length paces each access and overlapping or foreign cycles are ignored.
// Optional macro ISA_PIO_IRQ_EN adds per-port input-change pending bits and the IRQ output.
module isa_pio_port #(
    parameter logic [9:0] BASE_ADDR = 10'h2B0,
    parameter int         ADDR_BITS = 2,
    parameter int         NUM_PORTS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [9:0]             sa_i,
    input  logic [7:0]             sd_in_i,
    output logic [7:0]             sd_out_o,
    output logic                   sd_oe_o,
    input  logic                   ior_i,
    input  logic                   iow_i,
    input  logic                   aen_i,
    input  logic [8*NUM_PORTS-1:0] port_in_i,
    output logic [8*NUM_PORTS-1:0] port_out_o,
    output logic [NUM_PORTS-1:0]   port_dir_o,
    output logic                   irq_o
);

    localparam int                   NW      = 8 * NUM_PORTS;
    localparam logic [ADDR_BITS-1:0] CTL_OFF = '1;

    // The control register is one byte wide, so more than eight ports cannot be given a direction bit.
    if (NUM_PORTS < 1 || NUM_PORTS > (2**ADDR_BITS) - 1 || NUM_PORTS > 8) begin : g_bad_param
        $error("isa_pio_port: NUM_PORTS out of range for ADDR_BITS");
    end

    typedef enum logic [1:0] {IDLE, RD, WR, COMMIT} state_t;

    logic           ior_s1_q, ior_s2_q, iow_s1_q, iow_s2_q;
    logic           ior_prev_q, iow_prev_q;
    logic [1:0]     warm_q;
    logic [NW-1:0]  pin_s1_q, pin_s2_q;
    logic [7:0]     wdat_q;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   off_q;
    logic [7:0]             sd_out_q;
    logic                   sd_oe_q;
    logic [NW-1:0]          port_out_q;
    logic [NUM_PORTS-1:0]   port_dir_q;

    logic                   ior_fall, iow_fall, hit;
    logic [ADDR_BITS-1:0]   rd_off;
    logic [7:0]             rd_dat, ctl_rd;

    // Two-flop synchronisers for strobes and port pins; previous-value flops stay disarmed until
    // the synchronisers hold real samples, so a strobe already low at reset release never looks like a new edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ior_s1_q   <= 1'b1;
            ior_s2_q   <= 1'b1;
            iow_s1_q   <= 1'b1;
            iow_s2_q   <= 1'b1;
            ior_prev_q <= 1'b0;
            iow_prev_q <= 1'b0;
            warm_q     <= 2'b00;
            pin_s1_q   <= '0;
            pin_s2_q   <= '0;
        end else begin
            ior_s1_q <= ior_i;
            ior_s2_q <= ior_s1_q;
            iow_s1_q <= iow_i;
            iow_s2_q <= iow_s1_q;
            pin_s1_q <= port_in_i;
            pin_s2_q <= pin_s1_q;
            warm_q   <= {warm_q[0], 1'b1};
            if (warm_q[1]) begin
                ior_prev_q <= ior_s2_q;
                iow_prev_q <= iow_s2_q;
            end
        end
    end

    // Write data is captured every cycle the synced write strobe is low; the last sample is the one committed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdat_q <= 8'h00;
        end else if (!iow_s2_q) begin
            wdat_q <= sd_in_i;
        end
    end

    assign ior_fall = ior_prev_q & ~ior_s2_q;
    assign iow_fall = iow_prev_q & ~iow_s2_q;
    assign hit      = ~aen_i && (sa_i[9:ADDR_BITS] == BASE_ADDR[9:ADDR_BITS]);

    // On the IDLE->RD edge the offset is not latched yet, so read it straight from the bus.
    assign rd_off = (state_q == IDLE) ? sa_i[ADDR_BITS-1:0] : off_q;

`ifdef ISA_PIO_IRQ_EN
    logic [NW-1:0]        pin_prev_q;
    logic [NUM_PORTS-1:0] pend_q;
    logic                 irq_q;
    logic                 rd_exit;

    assign rd_exit = (state_q == RD) && ior_s2_q;

    // Pending bits latch input changes on input-direction ports; a completed read of the port clears its bit,
    // but a change in that same cycle wins so no edge is lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pin_prev_q <= '0;
            pend_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            pin_prev_q <= pin_s2_q;
            irq_q      <= |pend_q;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!port_dir_q[i] && (pin_s2_q[8*i +: 8] != pin_prev_q[8*i +: 8])) begin
                    pend_q[i] <= 1'b1;
                end else if (rd_exit && (off_q == ADDR_BITS'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign irq_o = irq_q;

    // Control readback: direction bits low, pending bits in the top nibble when they fit.
    always_comb begin
        ctl_rd = 8'(port_dir_q);
        if (NUM_PORTS <= 4) begin
            ctl_rd[7:4] = 4'(pend_q);
        end
    end
`else
    assign irq_o = 1'b0;

    // Control readback: direction bits, zero padded.
    always_comb begin
        ctl_rd = 8'(port_dir_q);
    end
`endif

    // Read mux: output ports echo their latch, input ports return the synced pins, unmapped offsets read zero.
    always_comb begin
        rd_dat = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_off == ADDR_BITS'(i)) begin
                rd_dat = port_dir_q[i] ? port_out_q[8*i +: 8] : pin_s2_q[8*i +: 8];
            end
        end
        if (rd_off == CTL_OFF) begin
            rd_dat = ctl_rd;
        end
    end

    // Bus-cycle FSM with registered read data, output enable and port/direction latches.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            off_q      <= '0;
            sd_out_q   <= 8'h00;
            sd_oe_q    <= 1'b0;
            port_out_q <= '0;
            port_dir_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ior_fall && iow_s2_q && hit) begin
                        state_q  <= RD;
                        off_q    <= sa_i[ADDR_BITS-1:0];
                        sd_oe_q  <= 1'b1;
                        sd_out_q <= rd_dat;
                    end else if (iow_fall && ior_s2_q && hit) begin
                        state_q <= WR;
                        off_q   <= sa_i[ADDR_BITS-1:0];
                    end
                end
                RD: begin
                    if (ior_s2_q) begin
                        state_q <= IDLE;
                        sd_oe_q <= 1'b0;
                    end else begin
                        sd_out_q <= rd_dat;
                    end
                end
                WR: begin
                    if (iow_s2_q) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (off_q == ADDR_BITS'(i)) begin
                            port_out_q[8*i +: 8] <= wdat_q;
                        end
                    end
                    if (off_q == CTL_OFF) begin
                        port_dir_q <= wdat_q[NUM_PORTS-1:0];
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_out_o   = sd_out_q;
    assign sd_oe_o    = sd_oe_q;
    assign port_out_o = port_out_q;
    assign port_dir_o = port_dir_q;

endmodule

// File: tb/tb_isa_pio_port.sv
module tb_isa_pio_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  sa;
    logic [7:0]  sd_in;
    logic [7:0]  sd_out;
    logic        sd_oe;
    logic        ior, iow, aen;
    logic [23:0] port_in;
    logic [23:0] port_out;
    logic [2:0]  port_dir;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    isa_pio_port #(.BASE_ADDR(10'h2B0), .ADDR_BITS(2), .NUM_PORTS(3)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .sa_i       (sa),
        .sd_in_i    (sd_in),
        .sd_out_o   (sd_out),
        .sd_oe_o    (sd_oe),
        .ior_i      (ior),
        .iow_i      (iow),
        .aen_i      (aen),
        .port_in_i  (port_in),
        .port_out_o (port_out),
        .port_dir_o (port_dir),
        .irq_o      (irq)
    );

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        bit          aen;
        logic [7:0]  d;
        logic [7:0]  pin0;
        logic [7:0]  exp_sd;
        bit          exp_oe;
        logic [2:0]  exp_dir;
        logic [23:0] exp_out;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [9:0] a, input logic en, output logic oe_seen, output logic [7:0] dat);
        @(negedge clk);
        sa  = a;
        aen = en;
        @(negedge clk);
        ior     = 1'b0;
        oe_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            oe_seen = oe_seen | sd_oe;
        end
        dat = sd_out;
        ior = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        sa    = a;
        aen   = 1'b0;
        sd_in = d;
        @(negedge clk);
        iow = 1'b0;
        repeat (6) @(negedge clk);
        iow = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic       oe_seen;
        logic [7:0] rdat;
        logic       seen;

        //            wr  addr     aen d      pin0   exp_sd oe dir     exp_out
        vecs[0]  = '{1'b0, 10'h2B3, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 24'h000000};
        vecs[1]  = '{1'b1, 10'h2B3, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 3'b111, 24'h000000};
        vecs[2]  = '{1'b1, 10'h2B1, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 3'b111, 24'h00A500};
        vecs[3]  = '{1'b0, 10'h2B1, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b1, 3'b111, 24'h00A500};
        vecs[4]  = '{1'b1, 10'h2B3, 1'b0, 8'h06, 8'h00, 8'h00, 1'b0, 3'b110, 24'h00A500};
        vecs[5]  = '{1'b0, 10'h2B0, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1, 3'b110, 24'h00A500};
        vecs[6]  = '{1'b0, 10'h2B0, 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0, 3'b110, 24'h00A500};
        vecs[7]  = '{1'b0, 10'h2F0, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b0, 3'b110, 24'h00A500};
        vecs[8]  = '{1'b1, 10'h2F0, 1'b0, 8'hFF, 8'h3C, 8'h00, 1'b0, 3'b110, 24'h00A500};
        vecs[9]  = '{1'b1, 10'h2B2, 1'b0, 8'h5A, 8'h3C, 8'h00, 1'b0, 3'b110, 24'h5AA500};
        vecs[10] = '{1'b0, 10'h2B2, 1'b0, 8'h00, 8'h3C, 8'h5A, 1'b1, 3'b110, 24'h5AA500};
        vecs[11] = '{1'b0, 10'h2B3, 1'b0, 8'h00, 8'h3C, 8'h06, 1'b1, 3'b110, 24'h5AA500};
        vecs[12] = '{1'b1, 10'h2B0, 1'b0, 8'h77, 8'h3C, 8'h00, 1'b0, 3'b110, 24'h5AA577};
        vecs[13] = '{1'b0, 10'h2B0, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1, 3'b110, 24'h5AA577};
        vecs[14] = '{1'b1, 10'h2B3, 1'b0, 8'h07, 8'h3C, 8'h00, 1'b0, 3'b111, 24'h5AA577};
        vecs[15] = '{1'b0, 10'h2B0, 1'b0, 8'h00, 8'h3C, 8'h77, 1'b1, 3'b111, 24'h5AA577};
        vecs[16] = '{1'b1, 10'h2B3, 1'b0, 8'hFF, 8'h3C, 8'h00, 1'b0, 3'b111, 24'h5AA577};
        vecs[17] = '{1'b0, 10'h2B3, 1'b0, 8'h00, 8'h3C, 8'h07, 1'b1, 3'b111, 24'h5AA577};

        rst_n   = 1'b0;
        sa      = 10'h000;
        sd_in   = 8'h00;
        ior     = 1'b1;
        iow     = 1'b1;
        aen     = 1'b0;
        port_in = 24'h000000;
        #1;
        check("reset sd_oe", {31'b0, sd_oe}, 32'd0);
        check("reset sd_out", {24'b0, sd_out}, 32'h00);
        check("reset port_out", {8'b0, port_out}, 32'h000000);
        check("reset port_dir", {29'b0, port_dir}, 32'd0);
        check("reset irq", {31'b0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            port_in[7:0] = vecs[i].pin0;
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].d);
            end else begin
                bus_read(vecs[i].addr, vecs[i].aen, oe_seen, rdat);
                check($sformatf("vec%0d sd_oe", i), {31'b0, oe_seen}, {31'b0, vecs[i].exp_oe});
                if (vecs[i].exp_oe) begin
                    check($sformatf("vec%0d sd_out", i), {24'b0, rdat}, {24'b0, vecs[i].exp_sd});
                end
            end
            check($sformatf("vec%0d port_dir", i), {29'b0, port_dir}, {29'b0, vecs[i].exp_dir});
            check($sformatf("vec%0d port_out", i), {8'b0, port_out}, {8'b0, vecs[i].exp_out});
            check($sformatf("vec%0d sd_oe idle", i), {31'b0, sd_oe}, 32'd0);
        end
        aen = 1'b0;

        // Both strobes low together at a hit address: nothing may happen.
        @(negedge clk);
        sa    = 10'h2B0;
        sd_in = 8'h11;
        @(negedge clk);
        ior  = 1'b0;
        iow  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | sd_oe;
        end
        ior = 1'b1;
        iow = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen = seen | sd_oe;
        end
        check("both-low sd_oe", {31'b0, seen}, 32'd0);
        check("both-low port_dir", {29'b0, port_dir}, 32'd7);
        check("both-low port_out", {8'b0, port_out}, 32'h5AA577);

        // Read latency: SD_OE rises on the 3rd edge after IOR falls, drops on the 3rd edge after it rises.
        @(negedge clk);
        sa = 10'h2B3;
        @(negedge clk);
        ior = 1'b0;
        @(negedge clk);
        check("rd lat e1 oe", {31'b0, sd_oe}, 32'd0);
        @(negedge clk);
        check("rd lat e2 oe", {31'b0, sd_oe}, 32'd0);
        @(negedge clk);
        check("rd lat e3 oe", {31'b0, sd_oe}, 32'd1);
        check("rd lat e3 data", {24'b0, sd_out}, 32'h07);
        ior = 1'b1;
        @(negedge clk);
        check("rd exit e1 oe", {31'b0, sd_oe}, 32'd1);
        @(negedge clk);
        check("rd exit e2 oe", {31'b0, sd_oe}, 32'd1);
        @(negedge clk);
        check("rd exit e3 oe", {31'b0, sd_oe}, 32'd0);
        repeat (3) @(negedge clk);

        // Write latency: new port value appears on the 4th edge after IOW rises.
        @(negedge clk);
        sa    = 10'h2B1;
        sd_in = 8'h3C;
        @(negedge clk);
        iow = 1'b0;
        repeat (5) @(negedge clk);
        iow = 1'b1;
        repeat (3) @(negedge clk);
        check("wr lat e3 port1", {24'b0, port_out[15:8]}, 32'hA5);
        @(negedge clk);
        check("wr lat e4 port1", {24'b0, port_out[15:8]}, 32'h3C);
        repeat (4) @(negedge clk);

        // Reset in the middle of a write cycle.
        @(negedge clk);
        sa    = 10'h2B1;
        sd_in = 8'hFF;
        @(negedge clk);
        iow = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst port_out", {8'b0, port_out}, 32'h000000);
        check("midrst port_dir", {29'b0, port_dir}, 32'd0);
        check("midrst sd_oe", {31'b0, sd_oe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        iow = 1'b1;
        repeat (8) @(negedge clk);
        check("post-rst no commit out", {8'b0, port_out}, 32'h000000);
        check("post-rst no commit dir", {29'b0, port_dir}, 32'd0);
        bus_write(10'h2B3, 8'h05);
        check("post-rst write dir", {29'b0, port_dir}, 32'd5);
        bus_write(10'h2B2, 8'hC3);
        check("post-rst write port2", {8'b0, port_out}, 32'hC30000);

`ifdef ISA_PIO_IRQ_EN
        bus_write(10'h2B3, 8'h00);
        bus_read(10'h2B0, 1'b0, oe_seen, rdat);
        repeat (2) @(negedge clk);
        check("irq clear before toggle", {31'b0, irq}, 32'd0);
        port_in[2] = ~port_in[2];
        repeat (4) @(negedge clk);
        check("irq after toggle", {31'b0, irq}, 32'd1);
        bus_read(10'h2B0, 1'b0, oe_seen, rdat);
        check("irq read data", {24'b0, rdat}, 32'h38);
        check("irq after read", {31'b0, irq}, 32'd0);
`else
        port_in[2] = ~port_in[2];
        repeat (6) @(negedge clk);
        check("irq tied low", {31'b0, irq}, 32'd0);
        bus_read(10'h2B3, 1'b0, oe_seen, rdat);
        check("ctl upper nibble", {24'b0, rdat}, 32'h05);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
